// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared 7-segment definitions for the receive-side display checker and for
// future encoder checks.
//   - SEG_A..SEG_G, SEG_DP : bit positions on the SEG bus
//   - POS_UNITS..POS_THOUSANDS : digit positions on the DIGIT bus
//   - PAT_0..PAT_F, SEG_PATTERNS : active-high segment patterns (bit0 = a)
//   - digit_class_e / classify_digit : blank / single / multi-hot DIGIT sorting
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int POS_UNITS     = 0;
  localparam int POS_TENS      = 1;
  localparam int POS_HUNDREDS  = 2;
  localparam int POS_THOUSANDS = 3;

  localparam logic [6:0] PAT_0 = 7'h3F;
  localparam logic [6:0] PAT_1 = 7'h06;
  localparam logic [6:0] PAT_2 = 7'h5B;
  localparam logic [6:0] PAT_3 = 7'h4F;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h6D;
  localparam logic [6:0] PAT_6 = 7'h7D;
  localparam logic [6:0] PAT_7 = 7'h07;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h6F;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h7C;
  localparam logic [6:0] PAT_C = 7'h39;
  localparam logic [6:0] PAT_D = 7'h5E;
  localparam logic [6:0] PAT_E = 7'h79;
  localparam logic [6:0] PAT_F = 7'h71;

  // Indexed by the hex value the pattern represents.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    PAT_F, PAT_E, PAT_D, PAT_C, PAT_B, PAT_A, PAT_9, PAT_8,
    PAT_7, PAT_6, PAT_5, PAT_4, PAT_3, PAT_2, PAT_1, PAT_0
  };

  typedef enum logic [1:0] {
    DIG_BLANK,
    DIG_SINGLE,
    DIG_MULTI
  } digit_class_e;

  // DIGIT is active-low: all ones is blank, exactly one zero is a position.
  function automatic digit_class_e classify_digit(input logic [3:0] digit_n);
    if (digit_n == 4'hF)   return DIG_BLANK;
    if ($onehot(~digit_n)) return DIG_SINGLE;
    return DIG_MULTI;
  endfunction

endpackage

// File: rtl/display_7_seg_rx_if.sv
// -----------------------------------------------------------------------------
// display_7_seg_rx_if
// Bus between a multiplexed 7-segment display and its receive-side checker.
//   SEG[7:0]    segment bus, SEG[0]=a .. SEG[6]=g, SEG[7]=dp
//   DIGIT[3:0]  active-low one-hot digit enables (bit0 = units)
//   units/tens/hundreds/thousands  decoded frame values
//   frame_valid one-cycle pulse on frame update
//   pat_err     one-cycle pulse on a bad capture
//   stale       level, no capture for the timeout period
// master: drives the display side, observes results.  slave: the checker.
// -----------------------------------------------------------------------------
interface display_7_seg_rx_if;
  logic [7:0] SEG;
  logic [3:0] DIGIT;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic       frame_valid;
  logic       pat_err;
  logic       stale;

  modport master (
    output SEG, DIGIT,
    input  units, tens, hundreds, thousands, frame_valid, pat_err, stale
  );

  modport slave (
    input  SEG, DIGIT,
    output units, tens, hundreds, thousands, frame_valid, pat_err, stale
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of an active-high 7-segment pattern (bit0 = a).
//   pattern [6:0] in   segment pattern
//   value   [3:0] out  hex value (0 when invalid)
//   valid         out  pattern is one of the 16 legal glyphs
// -----------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    // NOTE: outputs get defaults before the search loop so no path infers a latch.
    value = '0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        value = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_7_seg_rx.sv
// -----------------------------------------------------------------------------
// display_7_seg_rx
// Samples a multiplexed SEG/DIGIT bus, waits for each {DIGIT,SEG} value to hold
// for STABLE_CYCLES, decodes the captured glyph into a per-position holding
// register and publishes a coherent frame once every DIGIT_MASK position has
// been seen.
//   CLK, RST     clock, synchronous active-high reset
//   bus (slave)  SEG/DIGIT in; units..thousands, frame_valid, pat_err, stale out
// Optional: define DISPLAY_7_SEG_RX_SYNC_EN to put a 2-flop synchroniser in
// front of the sample register (asynchronous display sniffing, +2 latency).
// Pipeline: sample register -> capture register -> frame/holding update.
// -----------------------------------------------------------------------------
module display_7_seg_rx
  import seg7_pkg::*;
#(
  parameter int         STABLE_CYCLES  = 4,
  parameter logic [3:0] DIGIT_MASK     = 4'b0111,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
  input logic          CLK,
  input logic          RST,
  display_7_seg_rx_if.slave bus
);

  localparam int                SAMPLE_W   = 4 + SEG_DP + 1;
  localparam int                TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

  logic [SAMPLE_W-1:0] raw_sample;

  // Sample stage
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d;     // this dwell has already captured
  // Capture stage
  logic                cap_q, cap_d;
  logic [3:0]          cap_digit_q, cap_digit_d;
  logic [3:0]          cap_val_q, cap_val_d;
  logic                cap_ok_q, cap_ok_d;
  // Frame stage
  logic [3:0][3:0]     hold_q, hold_d;
  logic [3:0]          seen_q, seen_d;
  logic [3:0][3:0]     out_q, out_d;
  logic                frame_valid_q, frame_valid_d;
  logic                pat_err_q, pat_err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                stale_q, stale_d;

  logic [3:0] sample_digit;
  logic [6:0] pattern_raw;
  logic [6:0] pattern;
  logic [3:0] dec_value;
  logic       dec_valid;

  assign sample_digit = sample_q[SAMPLE_W-1 -: 4];
  assign pattern_raw  = sample_q[SEG_G:SEG_A];
  assign pattern      = SEG_ACTIVE_LOW ? ~pattern_raw : pattern_raw;

  seg7_pattern_decode u_decode (
    .pattern (pattern),
    .value   (dec_value),
    .valid   (dec_valid)
  );

  always_comb begin
    logic       changed;
    logic       capture;
    logic       good;
    logic [3:0] new_bit;
    logic [3:0] seen_next;

    changed = (raw_sample != sample_q);
    sample_d = raw_sample;

    // Dwell counter: restart at 1 on any change, saturate at the threshold.
    cnt_d = cnt_q;
    if (changed)                 cnt_d = 8'd1;
    else if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;

    // One capture per dwell; a blank DIGIT never captures.
    capture = (cnt_q == STABLE_MAX) && !done_q &&
              (classify_digit(sample_digit) != DIG_BLANK);
    done_d  = changed ? 1'b0 : (done_q | capture);

    cap_d       = capture;
    cap_digit_d = sample_digit;
    cap_val_d   = dec_value;
    cap_ok_d    = dec_valid;

    good    = cap_q && cap_ok_q && (classify_digit(cap_digit_q) == DIG_SINGLE);
    new_bit = good ? ~cap_digit_q : 4'b0000;

    hold_d = hold_q;
    for (int i = 0; i < 4; i++) begin
      if (new_bit[i]) hold_d[i] = cap_val_q;
    end

    // Completion forwards the just-captured value via hold_d.
    seen_next     = seen_q | new_bit;
    frame_valid_d = good && ((seen_next & DIGIT_MASK) == DIGIT_MASK);
    out_d         = frame_valid_d ? hold_d : out_q;
    seen_d        = frame_valid_d ? 4'b0000 : seen_next;
    pat_err_d     = cap_q && !good;

    tmo_d = tmo_q;
    if (cap_q)                tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    stale_d = cap_q ? 1'b0 : (stale_q | (tmo_d == TMO_MAX));
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q      <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      cap_q         <= 1'b0;
      cap_digit_q   <= '0;
      cap_val_q     <= '0;
      cap_ok_q      <= 1'b0;
      // NOTE: holding registers are reset too, so a partial frame never
      // survives RST into the next published frame.
      hold_q        <= '0;
      seen_q        <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      tmo_q         <= '0;
      stale_q       <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      cap_q         <= cap_d;
      cap_digit_q   <= cap_digit_d;
      cap_val_q     <= cap_val_d;
      cap_ok_q      <= cap_ok_d;
      hold_q        <= hold_d;
      seen_q        <= seen_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      pat_err_q     <= pat_err_d;
      tmo_q         <= tmo_d;
      stale_q       <= stale_d;
    end
  end

`ifdef DISPLAY_7_SEG_RX_SYNC_EN
  logic [SAMPLE_W-1:0] sync1_q, sync1_d;
  logic [SAMPLE_W-1:0] sync2_q, sync2_d;

  assign sync1_d = {bus.DIGIT, bus.SEG};
  assign sync2_d = sync1_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign raw_sample = sync2_q;
`else
  assign raw_sample = {bus.DIGIT, bus.SEG};
`endif

  assign bus.units       = out_q[POS_UNITS];
  assign bus.tens        = out_q[POS_TENS];
  assign bus.hundreds    = out_q[POS_HUNDREDS];
  assign bus.thousands   = out_q[POS_THOUSANDS];
  assign bus.frame_valid = frame_valid_q;
  assign bus.pat_err     = pat_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_display_7_seg_rx.sv
// -----------------------------------------------------------------------------
// tb_display_7_seg_rx
// Drives dwells of {DIGIT,SEG} onto the bus. A dwell-level reference model
// predicts frames (queued) and pat_err pulses; a monitor pops a frame on every
// frame_valid and compares.
// -----------------------------------------------------------------------------
module tb_display_7_seg_rx;

  localparam int         STABLE  = 4;
  localparam logic [3:0] MASK    = 4'b0111;
  localparam int         TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_7_seg_rx_if bus ();

  display_7_seg_rx #(
    .STABLE_CYCLES  (STABLE),
    .DIGIT_MASK     (MASK),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (dwell level) ----------------
  int tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  logic [3:0]  held [4];
  logic [3:0]  seen;
  logic [15:0] exp_q [$];
  int          exp_frames = 0;
  int          exp_perr   = 0;
  logic [3:0]  prev_d;
  logic [7:0]  prev_s;

  function automatic int decode_ref(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == int'(p)) return i;
    return -1;
  endfunction

  function automatic logic [7:0] seg_of(input int v);
    logic [6:0] p;
    p = 7'(tbl[v]);
    return {1'b1, ~p};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) held[i] = 4'h0;
    seen = 4'b0000;
  endtask

  task automatic model_dwell(input logic [3:0] d, input logic [7:0] s, input int len);
    int zeros;
    int pos;
    int v;
    zeros = 0;
    pos   = 0;
    if (len < STABLE || d == 4'hF) return;
    for (int i = 0; i < 4; i++) if (!d[i]) begin zeros++; pos = i; end
    v = decode_ref(~s[6:0]);
    if (zeros != 1 || v < 0) begin
      exp_perr++;
      return;
    end
    held[pos] = 4'(v);
    seen[pos] = 1'b1;
    if ((seen & MASK) == MASK) begin
      exp_q.push_back({held[3], held[2], held[1], held[0]});
      exp_frames++;
      seen = 4'b0000;
    end
  endtask

  // Inputs change on the falling edge and hold for len rising edges.
  task automatic dwell(input logic [3:0] d, input logic [7:0] s, input int len);
    logic [7:0] sv;
    sv = s;
    if (d == prev_d && sv == prev_s) sv[7] = ~sv[7];  // keep dwells distinct
    bus.DIGIT = d;
    bus.SEG   = sv;
    prev_d    = d;
    prev_s    = sv;
    model_dwell(d, sv, len);
    repeat (len) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  int frames_seen = 0;
  int perr_seen   = 0;

  always @(negedge clk) begin
    if (bus.pat_err === 1'b1) perr_seen++;
    if (bus.frame_valid === 1'b1) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("frame_unexpected_qsize", 0, 1);
      end else begin
        check("frame", {bus.thousands, bus.hundreds, bus.tens, bus.units},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0, p0;
    logic [3:0] d;
    logic [6:0] p;
    int r;

    model_reset();
    rst       = 1'b1;
    bus.DIGIT = 4'hF;
    bus.SEG   = 8'hFF;
    prev_d    = 4'hF;
    prev_s    = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_units",       bus.units,       0);
    check("rst_tens",        bus.tens,        0);
    check("rst_hundreds",    bus.hundreds,    0);
    check("rst_thousands",   bus.thousands,   0);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_pat_err",     bus.pat_err,     0);
    check("rst_stale",       bus.stale,       0);
    rst = 1'b0;

    // Stale: blank input, no captures.
    repeat (TIMEOUT - 1) @(negedge clk);
    check("stale_before_timeout", bus.stale, 0);
    @(negedge clk);
    check("stale_at_timeout", bus.stale, 1);
    dwell(4'b1110, seg_of(3), 10);
    check("stale_cleared_by_capture", bus.stale, 0);

    // Default loop: 3 / 7 / 9, 50 cycles each.
    f0 = frames_seen; p0 = perr_seen;
    for (int k = 0; k < 3; k++) begin
      dwell(4'b1110, 8'hB0, 50);
      dwell(4'b1101, 8'hF8, 50);
      dwell(4'b1011, 8'h90, 50);
    end
    dwell(4'hF, 8'hFF, 10);
    check("loop_frames", frames_seen - f0, 3);
    check("loop_no_pat_err", perr_seen - p0, 0);
    check("loop_units", bus.units, 3);
    check("loop_tens", bus.tens, 7);
    check("loop_hundreds", bus.hundreds, 9);
    check("loop_thousands", bus.thousands, 0);

    // Glitch filter: 2-cycle tens glitch inside a units dwell.
    f0 = frames_seen;
    dwell(4'b1110, seg_of(5), 20);
    dwell(4'b1101, seg_of(1), 2);
    dwell(4'b1110, seg_of(5), 20);
    dwell(4'b1101, seg_of(7), 20);
    dwell(4'b1011, seg_of(9), 20);
    dwell(4'hF, 8'hFF, 10);
    check("glitch_frames", frames_seen - f0, 1);
    check("glitch_tens_kept", bus.tens, 7);

    // Bad pattern on hundreds.
    f0 = frames_seen; p0 = perr_seen;
    dwell(4'b1110, seg_of(5), 10);
    dwell(4'b1101, seg_of(6), 10);
    dwell(4'b1011, 8'hFF ^ 8'h12, 10);
    dwell(4'hF, 8'hFF, 10);
    check("bad_pat_err", perr_seen - p0, 1);
    check("bad_no_frame", frames_seen - f0, 0);
    dwell(4'b1011, seg_of(4), 10);
    dwell(4'hF, 8'hFF, 10);
    check("bad_then_good_frame", frames_seen - f0, 1);

    // Multi-hot DIGIT.
    f0 = frames_seen; p0 = perr_seen;
    dwell(4'b1110, seg_of(2), 10);
    dwell(4'b1100, seg_of(8), 10);
    dwell(4'hF, 8'hFF, 10);
    check("multi_pat_err", perr_seen - p0, 1);
    dwell(4'b1011, seg_of(6), 10);
    dwell(4'hF, 8'hFF, 10);
    check("multi_seen_unchanged", frames_seen - f0, 0);
    dwell(4'b1101, seg_of(1), 10);
    dwell(4'hF, 8'hFF, 10);
    check("multi_then_frame", frames_seen - f0, 1);

    // Randomised dwells.
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        d = ~(4'b0001 << $urandom_range(0, 3));
        dwell(d, {1'($urandom_range(0, 1)), ~7'(tbl[$urandom_range(0, 15)])},
              $urandom_range(1, 10));
      end else if (r == 7) begin
        dwell(4'hF, 8'($urandom), $urandom_range(1, 10));
      end else if (r == 8) begin
        do d = 4'($urandom); while ($countones(~d) < 2);
        dwell(d, 8'($urandom), $urandom_range(1, 10));
      end else begin
        do p = 7'($urandom); while (decode_ref(p) >= 0);
        d = ~(4'b0001 << $urandom_range(0, 3));
        dwell(d, {1'b1, ~p}, $urandom_range(1, 10));
      end
    end
    dwell(4'hF, 8'hFF, 12);
    check("random_pat_err_count", perr_seen, exp_perr);
    check("random_frame_count", frames_seen, exp_frames);

    // Reset mid-frame.
    dwell(4'b1110, seg_of(1), 10);
    dwell(4'b1101, seg_of(2), 10);
    dwell(4'hF, 8'hFF, 10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_units", bus.units, 0);
    check("midrst_tens", bus.tens, 0);
    check("midrst_hundreds", bus.hundreds, 0);
    check("midrst_thousands", bus.thousands, 0);
    check("midrst_queue_empty", exp_q.size(), 0);
    model_reset();
    rst = 1'b0;
    f0 = frames_seen;
    dwell(4'b1110, seg_of(1), 10);
    dwell(4'b1101, seg_of(2), 10);
    dwell(4'b1011, seg_of(3), 10);
    dwell(4'hF, 8'hFF, 12);
    check("midrst_one_frame", frames_seen - f0, 1);
    check("midrst_frame_value",
          {bus.thousands, bus.hundreds, bus.tens, bus.units}, 16'h0321);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_pat_err_count", perr_seen, exp_perr);
    check("final_frame_count", frames_seen, exp_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
